// File: rtl/pellet_plotter.sv
// Sprite scan-out engine: walks a latched 5x5 bitmap in raster order, one cell
// per clock, and emits pixel writes (x, y, colour, plot) for a frame-buffer port.
module pellet_plotter #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [24:0]    shape_in,
    input  logic [X_W-1:0] base_x,
    input  logic [Y_W-1:0] base_y,
    input  logic [C_W-1:0] fg_colour,
    input  logic [C_W-1:0] bg_colour,
    input  logic           opaque,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [C_W-1:0] colour_out,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_load;
    logic   w_step;
    logic   w_last;

    // Latched draw parameters
    logic [24:0]    r_shape;
    logic [X_W-1:0] r_base_x;
    logic [Y_W-1:0] r_base_y;
    logic [C_W-1:0] r_fg;
    logic [C_W-1:0] r_bg;
    logic           r_opaque;

    // Position of the cell currently on the outputs
    logic [2:0]     r_row;
    logic [2:0]     r_col;
    logic [2:0]     w_row_next;
    logic [2:0]     w_col_next;

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [C_W-1:0] r_colour;
    logic           r_plot;

    assign w_last     = (r_row == 3'd4) && (r_col == 3'd4);
    assign w_col_next = (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;
    assign w_row_next = (r_col == 3'd4) ? r_row + 3'd1 : r_row;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Cell 0 is built straight from the inputs so it appears the cycle after start;
    // later cells come from the latched copy, shifted so the next bit is always [24].
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shape  <= '0;
            r_base_x <= '0;
            r_base_y <= '0;
            r_fg     <= '0;
            r_bg     <= '0;
            r_opaque <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else if (w_load) begin
            r_shape  <= {shape_in[23:0], 1'b0};
            r_base_x <= base_x;
            r_base_y <= base_y;
            r_fg     <= fg_colour;
            r_bg     <= bg_colour;
            r_opaque <= opaque;
            r_row    <= 3'd0;
            r_col    <= 3'd0;
            r_x      <= base_x;
            r_y      <= base_y;
            r_colour <= shape_in[24] ? fg_colour : bg_colour;
            r_plot   <= shape_in[24] | opaque;
        end else if (w_step) begin
            r_shape  <= {r_shape[23:0], 1'b0};
            r_row    <= w_row_next;
            r_col    <= w_col_next;
            r_x      <= r_base_x + X_W'(w_col_next);
            r_y      <= r_base_y + Y_W'(w_row_next);
            r_colour <= r_shape[24] ? r_fg : r_bg;
            r_plot   <= r_shape[24] | r_opaque;
        end else begin
            r_plot   <= 1'b0;
        end
    end

    assign x_out      = r_x;
    assign y_out      = r_y;
    assign colour_out = r_colour;
    assign plot       = r_plot;
    assign busy       = (r_state == S_SCAN);
    assign done       = (r_state == S_DONE);

endmodule

// File: doc/pellet_plotter.md
# pellet_plotter

Sprite scan-out engine that consumes a 25-bit 5x5 shape bitmap, such as the animated pellet frame from the pellet shaper, and converts it into a serial stream of pixel writes for the VGA frame-buffer adapter. On a start request it latches the shape, base coordinate and colours, then visits all 25 cells in raster order, one per clock. It asserts `plot` for each cell that must be written, then pulses `done`. It sits between the game-level draw sequencer, which is the requester, and the VGA adapter's `x`/`y`/`colour`/`plot` write port.

## Interface
- `X_W`, default 8: width of x coordinate.
- `Y_W`, default 7: width of y coordinate.
- `C_W`, default 3: width of colour.

Reset is asynchronous and active-high. The block has a single clock.

- `clock` in, 1: system clock; all state updates on rising edge.
- `reset` in, 1: asynchronous, active-high; forces IDLE and clears all outputs.
- `start` in, 1: draw request; sampled only in IDLE.
- `shape_in` in, 25: bitmap. Bit 24 is row 0 col 0 (top-left); bit index = 24 − (5·row + col).
- `base_x` in, X_W: x of top-left cell.
- `base_y` in, Y_W: y of top-left cell.
- `fg_colour` in, C_W: colour for set bits.
- `bg_colour` in, C_W: colour for clear bits (opaque mode only).
- `opaque` in, 1: 1 writes all 25 cells; 0 writes set bits only.
- `x_out` out, X_W: pixel x to adapter.
- `y_out` out, Y_W: pixel y to adapter.
- `colour_out` out, C_W: pixel colour to adapter.
- `plot` out, 1: write strobe, valid with `x_out`/`y_out`/`colour_out`.
- `busy` out, 1: high while scanning.
- `done` out, 1: one-cycle completion pulse.

## Operation
- States: IDLE, SCAN, DONE.
  - IDLE: if `start`=1, latch `shape_in`, `base_x`, `base_y`, `fg_colour`, `bg_colour`, `opaque`; set row=0, col=0; go to SCAN.
  - SCAN: each cycle, emit the current cell and advance col; when col=4, col←0 and row increments. After cell (4,4) is emitted, go to DONE.
  - DONE: assert `done` for one cycle, then return to IDLE unconditionally.
- Per-cell output, registered and presented in the cycle the cell is visited:
  - `x_out` = (latched base_x + col) mod 2^X_W.
  - `y_out` = (latched base_y + row) mod 2^Y_W.
  - `plot` = bit | opaque.
  - `colour_out` = bit ? fg : bg.
- Coordinate wrap at the screen edge is plain modular truncation; no clipping.
- Inputs other than `start` are don't-care outside the IDLE sampling cycle. Changes during SCAN have no effect.
- `start` in SCAN or DONE is ignored. It is not queued.
- Outside SCAN: `plot`=0. `x_out`, `y_out` and `colour_out` hold their last values; they are 0 after reset.
- A shape of all zeros with `opaque`=0 still takes the full 25 cycles with `plot` never asserted, then `done`.
- Reset mid-SCAN: immediate return to IDLE; `plot`, `busy` and `done` go to 0 asynchronously; no `done` is produced for the aborted draw.

## Timing
- Reset values: `x_out`=0, `y_out`=0, `colour_out`=0, `plot`=0, `busy`=0, `done`=0, state IDLE.
- `start` sampled high at edge N (in IDLE):
  - Cell k (k=0..24) is presented in cycle N+1+k.
  - `busy`=1 for cycles N+1..N+25.
  - `done`=1 in cycle N+26 only, with `busy`=0.
- Earliest next accepted `start` is at edge N+27, when state is IDLE again. Back-to-back throughput is one sprite per 27 cycles.
- The adapter is write-only with no backpressure; every `plot` cycle is consumed.

## Test plan
- Reset then idle:
  - Stimulus: assert `reset` asynchronously mid-cycle; hold `start`=0 for 50 cycles.
  - Required: all outputs 0 throughout.
- Transparent frame 0:
  - Stimulus: `shape_in`=0000000110011100110000000, base (10,20), fg=3'b110, `opaque`=0.
  - Required: exactly 7 `plot` pulses at (12,21), (13,21), (11,22), (12,22), (13,22), (11,23), (12,23), in that order, each with colour 110.
  - Required: `busy` high for 25 cycles; `done` in cycle N+26.
- Opaque frame 1:
  - Stimulus: `shape_in`=0000001100011100011000000, fg=3'b110, bg=3'b000, `opaque`=1, base (0,0).
  - Required: 25 consecutive `plot` pulses covering (0,0)..(4,4) in raster order.
  - Required: colour 110 exactly at (1,1), (2,1), (1,2), (2,2), (3,2), (2,3), (3,3); colour 000 elsewhere.
- Wrap and ignored start:
  - Stimulus: base (254,126), all-ones shape, `opaque`=0; pulse `start` again at cycle N+5.
  - Required: x sequence 254, 255, 0, 1, 2; y sequence 126, 127, 0, 1, 2.
  - Required: only one `done` pulse; the second `start` is ignored.
- Reset mid-operation:
  - Stimulus: assert `reset` at cycle N+12 of a draw.
  - Required: `plot` and `busy` drop immediately; no `done` pulse.
  - Required: a new `start` after reset release draws correctly from cell (0,0).
- Back-to-back draws:
  - Stimulus: hold `start`=1 continuously.
  - Required: a draw begins every 27 cycles; `done` pulses are exactly 27 cycles apart.
